// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle signed multiply/divide engine owning the HI/LO result pair
//   clk, reset           rising-edge clock, synchronous active-high reset
//   multStart, divStart  start requests, sampled only while idle (multiply wins a tie)
//   opA, opB             multiplicand/dividend and multiplier/divisor
//   busy                 high whenever not idle
//   done                 one-cycle pulse when hi/lo hold a new result
//   div0                 one-cycle pulse for a divide by zero (hi/lo untouched)
//   hi, lo               product upper/lower half, or remainder/quotient
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multStart,
    input  logic             divStart,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE, DZERO} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    // Booth register {A, Q, q-1}; A carries one guard bit so MIN*MIN cannot overflow
    logic [2*WIDTH+1:0] acc, acc_nxt;
    logic [WIDTH:0] mcand, a_sum;
    logic [WIDTH-1:0] rem, quo, dvs, rem_nxt, quo_nxt, q_fix, r_fix;
    logic [WIDTH:0] shl, sub;
    logic ge, sa, sb, last;
    assign last = cnt == CW'(WIDTH - 1);
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign div0 = state == DZERO;
    always_comb begin
        a_sum = acc[2*WIDTH+1:WIDTH+1] + (acc[1:0] == 2'b01 ? mcand : acc[1:0] == 2'b10 ? -mcand : '0);
        acc_nxt = $signed({a_sum, acc[WIDTH:0]}) >>> 1;
        shl = {rem, quo[WIDTH-1]};
        sub = shl - {1'b0, dvs};
        ge = shl >= {1'b0, dvs};
        rem_nxt = ge ? sub[WIDTH-1:0] : shl[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ge};
        q_fix = (sa ^ sb) ? -quo : quo;
        r_fix = sa ? -rem : rem;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = multStart ? MULT : divStart ? (opB == '0 ? DZERO : DIV) : IDLE;
            MULT:    state_nxt = last ? DONE : MULT;
            DIV:     state_nxt = last ? FIX : DIV;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            acc   <= '0;
            mcand <= '0;
            rem   <= '0;
            quo   <= '0;
            dvs   <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (multStart) begin
                        acc   <= {{(WIDTH+1){1'b0}}, opB, 1'b0};
                        mcand <= {opA[WIDTH-1], opA};
                    end else if (divStart) begin
                        sa  <= opA[WIDTH-1];
                        sb  <= opB[WIDTH-1];
                        quo <= opA[WIDTH-1] ? -opA : opA;
                        dvs <= opB[WIDTH-1] ? -opB : opB;
                        rem <= '0;
                    end
                end
                MULT: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    // the final step lands straight in hi/lo as DONE is entered
                    if (last) {hi, lo} <= acc_nxt[2*WIDTH:1];
                end
                DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    hi <= r_fix;
                    lo <= q_fix;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench for mult_div_unit against an arithmetic model
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic multStart = 1'b0;
    logic divStart = 1'b0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic busy, done, div0;
    logic [31:0] hi, lo;
    int checks = 0;
    int errors = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;
    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .multStart(multStart), .divStart(divStart),
        .opA(opA), .opB(opB), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // returns {hi, lo}: signed product, or {remainder, quotient} truncated toward zero
    function automatic logic [63:0] model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        longint pa, pb;
        logic [63:0] q, r;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        if (!is_div) return 64'(pa * pb);
        q = 64'(pa / pb);
        r = 64'(pa % pb);
        return {r[31:0], q[31:0]};
    endfunction
    task automatic do_op(input bit is_div, input logic [31:0] a, input logic [31:0] b, input bit both);
        int n;
        bit dz;
        logic [63:0] exp;
        dz = is_div && !both && b == 0;
        @(negedge clk);
        multStart = !is_div || both;
        divStart = is_div || both;
        opA = a;
        opB = b;
        @(negedge clk);
        multStart = 1'b0;
        divStart = 1'b0;
        opA = $urandom;
        opB = $urandom;
        n = 1;
        check("busy_after_accept", 64'(busy), 64'd1);
        while (!(done || div0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), dz ? 64'd1 : (is_div && !both) ? 64'd34 : 64'd33);
        check("done_flag", 64'(done), dz ? 64'd0 : 64'd1);
        check("div0_flag", 64'(div0), dz ? 64'd1 : 64'd0);
        exp = dz ? {prev_hi, prev_lo} : model(is_div && !both, a, b);
        check(is_div ? "div_hilo" : "mult_hilo", {hi, lo}, exp);
        prev_hi = exp[63:32];
        prev_lo = exp[31:0];
        @(negedge clk);
        check("pulse_end", {62'd0, done, div0}, 64'd0);
        check("idle_after", 64'(busy), 64'd0);
    endtask
    initial begin
        int n;
        int seen;
        logic [31:0] a, b;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_flags", {62'd0, done, div0}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        do_op(0, 32'd7, -32'sd3, 0);
        check("t1_hi", 64'(hi), 64'hFFFFFFFF);
        check("t1_lo", 64'(lo), 64'hFFFFFFEB);
        do_op(1, -32'sd7, 32'd2, 0);
        check("t2_lo", 64'(lo), 64'hFFFFFFFD);
        check("t2_hi", 64'(hi), 64'hFFFFFFFF);
        do_op(1, 32'd5, 32'd0, 0);
        do_op(1, 32'd4, 32'd5, 1);
        check("t4_lo", 64'(lo), 64'd20);
        check("t4_hi", 64'(hi), 64'd0);
        do_op(1, 32'h80000000, 32'hFFFFFFFF, 0);
        check("min_div_lo", 64'(lo), 64'h80000000);
        check("min_div_hi", 64'(hi), 64'd0);
        do_op(0, 32'h80000000, 32'h80000000, 0);
        check("min_mul_hi", 64'(hi), 64'h40000000);
        check("min_mul_lo", 64'(lo), 64'd0);
        // reset in the middle of a multiply
        @(negedge clk);
        multStart = 1'b1;
        opA = 32'd11;
        opB = 32'd13;
        @(negedge clk);
        multStart = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        prev_hi = '0;
        prev_lo = '0;
        do_op(0, 32'd2, 32'd3, 0);
        check("after_abort_lo", 64'(lo), 64'd6);
        // multStart held: done pulses spaced WIDTH+2 apart
        @(negedge clk);
        multStart = 1'b1;
        opA = 32'd9;
        opB = -32'sd6;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first", 64'(done), 64'd1);
        @(negedge clk);
        n = 1;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        multStart = 1'b0;
        check("b2b_spacing", 64'(n), 64'd34);
        check("b2b_lo", 64'(lo), 64'hFFFFFFCA);
        repeat (2) @(negedge clk);
        check("b2b_stop", 64'(busy), 64'd0);
        prev_hi = hi;
        prev_lo = lo;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'(int'($urandom_range(0, 6)) - 3);
                2: a = 32'h80000000;
                default: ;
            endcase
            do_op(bit'(i % 2), a, b, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
